rvh_l1d_ld_wb_queue: RTL and testbench
======================================

# rvh_l1d_ld_wb_queue

Load writeback queue sitting directly downstream of the L1D load hit-response stage. Captures each cycle's load writeback (ROB tag, physical destination tag, 64-bit load data, refill origin) and page-table-walk response, buffers them in FIFO order, and presents them to the shared ROB/integer-PRF writeback port and to the PTW under ready/valid handshakes. Signals a stall back to the load pipeline early enough that in-flight loads never overflow it.

## Interface
- DEPTH, 4, writeback FIFO entries; power of two, >= 4
- STALL_SLACK, 2, load-pipe stages in flight between stall assertion and a blocked issue
- ROB_TAG_WIDTH, 4, ROB tag width
- PREG_TAG_WIDTH, 6, integer physical register tag width
- XLEN, 64, data width
- PTW_ID_WIDTH, 1, PTW walk id width
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- in_wb_vld_i  in  1  load writeback valid (ROB and PRF writeback valid are identical upstream)
- in_rob_tag_i  in  ROB_TAG_WIDTH  ROB tag
- in_prf_tag_i  in  PREG_TAG_WIDTH  destination physical register
- in_prf_data_i  in  XLEN  sign/zero-extended load data
- in_from_mlfb_i  in  1  data came from a miss-buffer refill
- in_ptw_vld_i  in  1  PTW walk response valid
- in_ptw_id_i  in  PTW_ID_WIDTH  walk id
- in_ptw_pte_i  in  XLEN  PTE
- out_wb_vld_o  out  1  head entry valid (drives both ROB and PRF writeback valid)
- out_wb_rdy_i  in  1  writeback port accepts
- out_rob_tag_o / out_prf_tag_o / out_prf_data_o / out_from_mlfb_o  out  as inputs  head entry fields
- ptw_walk_vld_o  out  1  PTW response valid
- ptw_walk_rdy_i  in  1  PTW accepts
- ptw_walk_id_o  out  PTW_ID_WIDTH; ptw_walk_pte_o  out  XLEN
- ld_stall_o  out  1  load pipeline must stop issuing
- count_o  out  log2(DEPTH)+1  current writeback occupancy
- overflow_o  out  1  sticky error: an input was dropped

## Operation
- Writeback FIFO: write pointer, read pointer (log2(DEPTH) bits, natural wrap), count register.
- Enqueue when in_wb_vld_i and (count < DEPTH or dequeue this cycle). Dequeue when out_wb_vld_o & out_wb_rdy_i.
- Simultaneous enq+deq: both pointers advance, count unchanged; legal at full and at count==1.
- out_wb_vld_o = (count != 0); head fields read from storage at read pointer. No flow-through.
- in_wb_vld_i while full and no dequeue: input dropped, overflow_o set, held until reset.
- PTW path: one-entry holding register. Load when in_ptw_vld_i and (empty or ptw_walk_rdy_i). If occupied, not draining, and new response arrives: drop it, set overflow_o.
- ld_stall_o = (count >= DEPTH - STALL_SLACK) | ptw_walk_vld_o.
- Ordering: writebacks leave strictly in arrival order; from_mlfb carried, not prioritised.

## Timing
- Enqueue at edge N -> visible on out_* from cycle N+1; minimum latency 1 cycle.
- Dequeue handshake completes at the edge where vld & rdy; next head visible the following cycle.
- out_* fields stable while out_wb_vld_o high and out_wb_rdy_i low.
- ld_stall_o is a registered-state function (no combinational path from any *_i valid).
- Reset (async, any time incl. mid-transfer): pointers, count, storage, PTW register, overflow_o cleared; all outputs 0 immediately; in-flight entries discarded.

## Structure
- ROB_TAG_WIDTH, PREG_TAG_WIDTH, XLEN, PTW_ID_WIDTH, and a packed writeback-entry typedef {rob_tag, prd, data, from_mlfb} in rvh_l1d_pkg.
- Natural sub-module: sync_fifo (parameterised width/depth, count output) instantiated for the writeback path; PTW register inline.

## Test plan
- Single load: in_wb_vld_i=1, rob_tag=3, prd=17, data=0xFFFF_FFFF_FFFF_FF80, rdy=1 -> next cycle out_wb_vld_o=1 with same fields, count returns to 0 a cycle later.
- Backpressure: rdy=0, enqueue tags 0..3 -> ld_stall_o rises when count=2, count_o=4; raise rdy -> tags drain 0,1,2,3 in order, one per cycle.
- Full with simultaneous enq+deq: count=4, rdy=1, enqueue tag 9 -> count stays 4, tag 9 emerges last, overflow_o=0.
- Overflow: count=4, rdy=0, enqueue tag 5 -> dropped, overflow_o=1 sticky, count_o=4.
- PTW: in_ptw_vld_i id=1 pte=0x2000_0CF with ptw_walk_rdy_i=0 -> ptw_walk_vld_o=1, ld_stall_o=1; second response dropped and overflow_o=1; rdy=1 -> vld clears next cycle.
- Async reset mid-drain with count=3 -> all outputs 0 immediately, count_o=0, no stale entry after release.

Source files
------------

// File: rtl/rvh_l1d_pkg.sv
// Shared L1D widths and the packed load-writeback entry carried through the writeback queue.
package rvh_l1d_pkg;

  localparam int ROB_TAG_WIDTH  = 4;
  localparam int PREG_TAG_WIDTH = 6;
  localparam int XLEN           = 64;
  localparam int PTW_ID_WIDTH   = 1;

  typedef struct packed {
    logic [ROB_TAG_WIDTH-1:0]  rob_tag;
    logic [PREG_TAG_WIDTH-1:0] prd;
    logic [XLEN-1:0]           data;
    logic                      from_mlfb;
  } ld_wb_entry_t;

  localparam int LD_WB_ENTRY_WIDTH = $bits(ld_wb_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers and an occupancy counter; head is read from storage.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_fire,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_fire;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_fire  = pop & (count != '0);
  assign push_fire = push & ((count != FULL_CNT) | pop_fire);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_fire) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvh_l1d_ld_wb_queue.sv
// Load writeback queue: buffers load writebacks in order for the ROB/PRF port and holds one PTW response.
module rvh_l1d_ld_wb_queue
  import rvh_l1d_pkg::*;
#(
  parameter  int DEPTH       = 4,
  parameter  int STALL_SLACK = 2,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_wb_vld_i,
  input  logic [ROB_TAG_WIDTH-1:0]  in_rob_tag_i,
  input  logic [PREG_TAG_WIDTH-1:0] in_prf_tag_i,
  input  logic [XLEN-1:0]           in_prf_data_i,
  input  logic                      in_from_mlfb_i,
  input  logic                      in_ptw_vld_i,
  input  logic [PTW_ID_WIDTH-1:0]   in_ptw_id_i,
  input  logic [XLEN-1:0]           in_ptw_pte_i,
  output logic                      out_wb_vld_o,
  input  logic                      out_wb_rdy_i,
  output logic [ROB_TAG_WIDTH-1:0]  out_rob_tag_o,
  output logic [PREG_TAG_WIDTH-1:0] out_prf_tag_o,
  output logic [XLEN-1:0]           out_prf_data_o,
  output logic                      out_from_mlfb_o,
  output logic                      ptw_walk_vld_o,
  input  logic                      ptw_walk_rdy_i,
  output logic [PTW_ID_WIDTH-1:0]   ptw_walk_id_o,
  output logic [XLEN-1:0]           ptw_walk_pte_o,
  output logic                      ld_stall_o,
  output logic [CW-1:0]             count_o,
  output logic                      overflow_o
);

  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - STALL_SLACK);

  // Handshakes: a transfer happens at the rising edge where vld and rdy are both high; a
  // producer holds vld and its fields steady until then, and rdy never depends on vld.
  ld_wb_entry_t in_entry;
  ld_wb_entry_t head_entry;
  logic         wb_deq;
  logic         wb_push_fire;
  logic         wb_drop;
  logic         ptw_load;
  logic         ptw_drop;

  assign in_entry = '{rob_tag: in_rob_tag_i, prd: in_prf_tag_i,
                      data: in_prf_data_i, from_mlfb: in_from_mlfb_i};

  sync_fifo #(
    .WIDTH (LD_WB_ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_wb_vld_i),
    .push_data (in_entry),
    .push_fire (wb_push_fire),
    .pop       (wb_deq),
    .head      (head_entry),
    .count     (count_o)
  );

  assign out_wb_vld_o    = (count_o != '0);
  assign wb_deq          = out_wb_vld_o & out_wb_rdy_i;
  assign wb_drop         = in_wb_vld_i & ~wb_push_fire;
  assign out_rob_tag_o   = head_entry.rob_tag;
  assign out_prf_tag_o   = head_entry.prd;
  assign out_prf_data_o  = head_entry.data;
  assign out_from_mlfb_o = head_entry.from_mlfb;

  // The PTW holding register refills in the same cycle it drains.
  assign ptw_load = in_ptw_vld_i & (~ptw_walk_vld_o | ptw_walk_rdy_i);
  assign ptw_drop = in_ptw_vld_i & ptw_walk_vld_o & ~ptw_walk_rdy_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptw_walk_vld_o <= 1'b0;
      ptw_walk_id_o  <= '0;
      ptw_walk_pte_o <= '0;
    end else if (ptw_load) begin
      ptw_walk_vld_o <= 1'b1;
      ptw_walk_id_o  <= in_ptw_id_i;
      ptw_walk_pte_o <= in_ptw_pte_i;
    end else if (ptw_walk_rdy_i) begin
      ptw_walk_vld_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_o <= 1'b0;
    else if (wb_drop | ptw_drop) overflow_o <= 1'b1;
  end

  assign ld_stall_o = (count_o >= STALL_CNT) | ptw_walk_vld_o;

endmodule

// File: tb/tb_rvh_l1d_ld_wb_queue.sv
// Bench for rvh_l1d_ld_wb_queue: directed scenarios with literal expectations plus a random phase
// checked every cycle against a queue-based model of the writeback and PTW paths.
module tb_rvh_l1d_ld_wb_queue;

  localparam int DEPTH = 4;
  localparam int SLACK = 2;
  localparam int EW    = 4 + 6 + 64 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_wb_vld_i = 0;
  logic [3:0]  in_rob_tag_i = '0;
  logic [5:0]  in_prf_tag_i = '0;
  logic [63:0] in_prf_data_i = '0;
  logic        in_from_mlfb_i = 0;
  logic        in_ptw_vld_i = 0;
  logic [0:0]  in_ptw_id_i = '0;
  logic [63:0] in_ptw_pte_i = '0;
  logic        out_wb_rdy_i = 0;
  logic        ptw_walk_rdy_i = 0;
  logic        out_wb_vld_o;
  logic [3:0]  out_rob_tag_o;
  logic [5:0]  out_prf_tag_o;
  logic [63:0] out_prf_data_o;
  logic        out_from_mlfb_o;
  logic        ptw_walk_vld_o;
  logic [0:0]  ptw_walk_id_o;
  logic [63:0] ptw_walk_pte_o;
  logic        ld_stall_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  rvh_l1d_ld_wb_queue #(.DEPTH(DEPTH), .STALL_SLACK(SLACK)) dut (
    .clk(clk), .rst(rst),
    .in_wb_vld_i(in_wb_vld_i), .in_rob_tag_i(in_rob_tag_i), .in_prf_tag_i(in_prf_tag_i),
    .in_prf_data_i(in_prf_data_i), .in_from_mlfb_i(in_from_mlfb_i),
    .in_ptw_vld_i(in_ptw_vld_i), .in_ptw_id_i(in_ptw_id_i), .in_ptw_pte_i(in_ptw_pte_i),
    .out_wb_vld_o(out_wb_vld_o), .out_wb_rdy_i(out_wb_rdy_i),
    .out_rob_tag_o(out_rob_tag_o), .out_prf_tag_o(out_prf_tag_o),
    .out_prf_data_o(out_prf_data_o), .out_from_mlfb_o(out_from_mlfb_o),
    .ptw_walk_vld_o(ptw_walk_vld_o), .ptw_walk_rdy_i(ptw_walk_rdy_i),
    .ptw_walk_id_o(ptw_walk_id_o), .ptw_walk_pte_o(ptw_walk_pte_o),
    .ld_stall_o(ld_stall_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic vld, input logic [3:0] rob, input logic [5:0] prd,
                          input logic [63:0] data, input logic mlfb);
    in_wb_vld_i    = vld;
    in_rob_tag_i   = rob;
    in_prf_tag_i   = prd;
    in_prf_data_i  = data;
    in_from_mlfb_i = mlfb;
  endtask

  task automatic drive_ptw(input logic vld, input logic [0:0] id, input logic [63:0] pte);
    in_ptw_vld_i = vld;
    in_ptw_id_i  = id;
    in_ptw_pte_i = pte;
  endtask

  // ---------------- scoreboard / model ----------------
  // Writebacks are a bounded in-order queue; the PTW path holds at most one response.
  logic [EW-1:0] exp_q[$];
  logic          m_ptw_occ = 1'b0;
  logic [0:0]    m_ptw_id  = '0;
  logic [63:0]   m_ptw_pte = '0;
  logic          m_ovf     = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_ptw_occ <= 1'b0;
      m_ptw_id  <= '0;
      m_ptw_pte <= '0;
      m_ovf     <= 1'b0;
    end else begin
      if (exp_q.size() > 0 && out_wb_rdy_i) void'(exp_q.pop_front());
      if (in_wb_vld_i) begin
        if (exp_q.size() < DEPTH)
          exp_q.push_back({in_rob_tag_i, in_prf_tag_i, in_prf_data_i, in_from_mlfb_i});
        else
          m_ovf <= 1'b1;
      end
      if (in_ptw_vld_i) begin
        if (!m_ptw_occ || ptw_walk_rdy_i) begin
          m_ptw_occ <= 1'b1;
          m_ptw_id  <= in_ptw_id_i;
          m_ptw_pte <= in_ptw_pte_i;
        end else begin
          m_ovf <= 1'b1;
        end
      end else if (ptw_walk_rdy_i) begin
        m_ptw_occ <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] h;
    chk("m_wb_vld",   out_wb_vld_o, exp_q.size() != 0);
    chk("m_count",    count_o, exp_q.size());
    chk("m_stall",    ld_stall_o, (exp_q.size() >= DEPTH - SLACK) || m_ptw_occ);
    chk("m_ptw_vld",  ptw_walk_vld_o, m_ptw_occ);
    chk("m_overflow", overflow_o, m_ovf);
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("m_rob_tag", out_rob_tag_o, h[74:71]);
      chk("m_prf_tag", out_prf_tag_o, h[70:65]);
      chk("m_data",    out_prf_data_o, h[64:1]);
      chk("m_mlfb",    out_from_mlfb_o, h[0]);
    end
    if (m_ptw_occ) begin
      chk("m_ptw_id",  ptw_walk_id_o, m_ptw_id);
      chk("m_ptw_pte", ptw_walk_pte_o, m_ptw_pte);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int order[4];
    order = '{1, 2, 3, 9};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_wb_vld", out_wb_vld_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_stall", ld_stall_o, 0);
    chk("rst_overflow", overflow_o, 0);

    // single load, one-cycle latency
    out_wb_rdy_i = 1;
    drive_wb(1, 4'd3, 6'd17, 64'hFFFF_FFFF_FFFF_FF80, 0);
    step();
    drive_wb(0, 0, 0, 0, 0);
    chk("single_vld", out_wb_vld_o, 1);
    chk("single_rob", out_rob_tag_o, 3);
    chk("single_prf", out_prf_tag_o, 17);
    chk("single_data", out_prf_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    chk("single_count", count_o, 1);
    step();
    chk("single_drained", count_o, 0);
    chk("single_vld_low", out_wb_vld_o, 0);

    // backpressure fill
    out_wb_rdy_i = 0;
    for (int t = 0; t < 4; t++) begin
      drive_wb(1, 4'(t), 6'(t + 8), {$urandom, $urandom}, t[0]);
      step();
      chk("bp_count", count_o, t + 1);
      chk("bp_stall", ld_stall_o, (t + 1) >= 2);
    end

    // full with simultaneous enqueue and dequeue
    chk("full_head0", out_rob_tag_o, 0);
    out_wb_rdy_i = 1;
    drive_wb(1, 4'd9, 6'd40, 64'h9999, 1);
    step();
    drive_wb(0, 0, 0, 0, 0);
    chk("full_count", count_o, 4);
    chk("full_overflow", overflow_o, 0);
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", out_rob_tag_o, order[k]);
      step();
    end
    chk("drain_empty", count_o, 0);

    // overflow at full with no dequeue
    out_wb_rdy_i = 0;
    for (int t = 0; t < 4; t++) begin
      drive_wb(1, 4'(10 + t), 6'(t), 64'(t), 0);
      step();
    end
    drive_wb(1, 4'd5, 6'd5, 64'h5, 0);
    step();
    drive_wb(0, 0, 0, 0, 0);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_count", count_o, 4);
    chk("ovf_head", out_rob_tag_o, 10);
    repeat (2) step();
    chk("ovf_sticky", overflow_o, 1);

    // async reset mid-drain
    out_wb_rdy_i = 1;
    step();
    chk("mid_count3", count_o, 3);
    rst = 1;
    #1;
    chk("arst_wb_vld", out_wb_vld_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_overflow", overflow_o, 0);
    chk("arst_stall", ld_stall_o, 0);
    chk("arst_data", out_prf_data_o, 0);
    step();
    rst = 0;
    step();
    chk("post_rst_vld", out_wb_vld_o, 0);
    chk("post_rst_count", count_o, 0);

    // PTW holding register
    ptw_walk_rdy_i = 0;
    drive_ptw(1, 1'b1, 64'h2000_0CF);
    step();
    drive_ptw(1, 1'b0, 64'h1234);
    chk("ptw_vld", ptw_walk_vld_o, 1);
    chk("ptw_stall", ld_stall_o, 1);
    chk("ptw_id", ptw_walk_id_o, 1);
    chk("ptw_pte", ptw_walk_pte_o, 64'h2000_0CF);
    step();
    drive_ptw(0, 0, 0);
    chk("ptw_drop_ovf", overflow_o, 1);
    chk("ptw_pte_kept", ptw_walk_pte_o, 64'h2000_0CF);
    ptw_walk_rdy_i = 1;
    step();
    chk("ptw_vld_clr", ptw_walk_vld_o, 0);
    chk("ptw_stall_clr", ld_stall_o, 0);

    // random phase, model-checked each cycle
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      drive_wb($urandom_range(0, 99) < 55, 4'($urandom), 6'($urandom),
               {$urandom, $urandom}, 1'($urandom));
      drive_ptw($urandom_range(0, 99) < 20, 1'($urandom), {$urandom, $urandom});
      out_wb_rdy_i   = $urandom_range(0, 99) < 60;
      ptw_walk_rdy_i = $urandom_range(0, 99) < 50;
      if (i == 1500) begin
        #2 rst = 1;
        step();
        rst = 0;
      end else begin
        step();
      end
    end
    drive_wb(0, 0, 0, 0, 0);
    drive_ptw(0, 0, 0);
    out_wb_rdy_i = 1;
    ptw_walk_rdy_i = 1;
    repeat (8) step();
    chk("final_empty", count_o, 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
